// File: rtl/perf_types.sv
// Shared types and address-map constants for the performance counter bank.
// Pure declarations; no logic, no latency, no backpressure.
// Imported by perf_channel and perf_counter_bank.
package perf_types;

    typedef enum logic {
        PERF_LEVEL = 1'b0,
        PERF_RUN   = 1'b1
    } perf_mode_t;

    typedef struct packed {
        logic [3:0] thresh;
        logic       rsvd;
        logic       sat;
        perf_mode_t mode;
        logic       en;
    } perf_cfg_t;

    localparam logic [6:0] PERF_CNT_OFS  = 7'h00;
    localparam logic [6:0] PERF_CFG_OFS  = 7'h20;
    localparam logic [6:0] PERF_STAT_OFS = 7'h40;
    localparam logic [6:0] PERF_CTRL_OFS = 7'h42;

    localparam perf_cfg_t PERF_CFG_RST = '{thresh: 4'd0, rsvd: 1'b0, sat: 1'b0,
                                           mode: PERF_LEVEL, en: 1'b1};

endpackage

// File: rtl/perf_channel.sv
// One event counter with run tracker and config register; emits an overflow pulse.
// Latency: count updates on the qualifying edge, visible the following cycle.
// No backpressure: clear beats counter write beats increment.
module perf_channel
    import perf_types::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             event_in,
    input  logic             freeze,
    input  logic             clear,
    input  logic             cnt_wr,
    input  logic             cfg_wr,
    input  logic [15:0]      wdata,
    output logic [CNT_W-1:0] cnt,
    output perf_cfg_t        cfg,
    output logic             ovf
);

    logic [3:0] run_len;
    logic       inc;
    logic       all_ones;
    logic       disable_now;
    logic       unused_wdata;

    assign unused_wdata = ^wdata;

    always_comb begin
        inc         = cfg.en & ~freeze & event_in &
                      ((cfg.mode == PERF_LEVEL) | (run_len == cfg.thresh));
        all_ones    = &cnt;
        // Overflow only from a real increment; clears and loads drop the event.
        ovf         = inc & all_ones & ~clear & ~cnt_wr;
        disable_now = ~cfg.en | (cfg_wr & ~wdata[0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            cfg     <= PERF_CFG_RST;
            run_len <= 4'd0;
        end else begin
            if (clear) begin
                cnt <= '0;
            end else if (cnt_wr) begin
                cnt <= wdata[CNT_W-1:0];
            end else if (inc) begin
                cnt <= all_ones ? (cfg.sat ? cnt : '0) : cnt + CNT_W'(1);
            end

            if (cfg_wr) begin
                cfg <= '{thresh: wdata[7:4], rsvd: 1'b0, sat: wdata[2],
                         mode: perf_mode_t'(wdata[1]), en: wdata[0]};
            end

            // Tracker runs through freeze so a run straddling it is not recounted.
            if (disable_now || !event_in) begin
                run_len <= 4'd0;
            end else if (run_len != 4'hF) begin
                run_len <= run_len + 4'd1;
            end
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// Memory-mapped bank of event counters with sticky overflow status, freeze and clear.
// Latency: reads combinational (pre-edge value); writes and counts land on the next edge.
// No backpressure: every MMIO access in the window completes in its own cycle.
module perf_counter_bank
    import perf_types::*;
#(
    parameter int          NUM_CH    = 9,
    parameter int          CNT_W     = 16,
    parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] event_in,
    input  logic [15:0]       mmio_addr,
    input  logic              mmio_read,
    input  logic              mmio_write,
    input  logic [15:0]       mmio_wdata,
    output logic              mmio_hit,
    output logic [15:0]       mmio_rdata,
    output logic              overflow_irq
);

    logic [6:0]        ofs;
    logic [3:0]        ch;
    logic              in_win, ch_ok, is_cnt, is_cfg, is_stat, is_ctrl, wr;
    logic              clear_all;
    logic [NUM_CH-1:0] status_q;
    logic [NUM_CH-1:0] ovf_vec;
    logic              freeze_q, irq_en_q;
    logic [CNT_W-1:0]  cnt_arr [NUM_CH];
    perf_cfg_t         cfg_arr [NUM_CH];

    always_comb begin
        ofs       = mmio_addr[6:0];
        ch        = ofs[4:1];
        in_win    = (mmio_addr[15:7] == BASE_ADDR[15:7]);
        ch_ok     = ({1'b0, ch} < 5'(NUM_CH)) & ~ofs[0];
        is_cnt    = in_win & ch_ok & (ofs[6:5] == PERF_CNT_OFS[6:5]);
        is_cfg    = in_win & ch_ok & (ofs[6:5] == PERF_CFG_OFS[6:5]);
        is_stat   = in_win & (ofs == PERF_STAT_OFS);
        is_ctrl   = in_win & (ofs == PERF_CTRL_OFS);
        mmio_hit  = (is_cnt | is_cfg | is_stat | is_ctrl) & (mmio_read | mmio_write);
        wr        = mmio_hit & mmio_write;
        clear_all = wr & is_ctrl & mmio_wdata[2];
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        perf_channel #(.CNT_W(CNT_W)) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .event_in (event_in[i]),
            .freeze   (freeze_q),
            .clear    (clear_all),
            .cnt_wr   (wr & is_cnt & (ch == 4'(i))),
            .cfg_wr   (wr & is_cfg & (ch == 4'(i))),
            .wdata    (mmio_wdata),
            .cnt      (cnt_arr[i]),
            .cfg      (cfg_arr[i]),
            .ovf      (ovf_vec[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= '0;
            freeze_q <= 1'b0;
            irq_en_q <= 1'b0;
        end else begin
            // A same-edge overflow is ORed in after W1C so the set wins.
            if (clear_all) begin
                status_q <= '0;
            end else begin
                status_q <= (status_q & ~((wr & is_stat) ? mmio_wdata[NUM_CH-1:0] : '0))
                            | ovf_vec;
            end
            if (wr && is_ctrl) begin
                freeze_q <= mmio_wdata[0];
                irq_en_q <= mmio_wdata[1];
            end
        end
    end

    assign overflow_irq = irq_en_q & (|status_q);

    always_comb begin
        mmio_rdata = 16'h0000;
        if (mmio_hit) begin
            if (is_stat) mmio_rdata = 16'(status_q);
            if (is_ctrl) mmio_rdata = {14'd0, irq_en_q, freeze_q};
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch == 4'(i)) begin
                    if (is_cnt) mmio_rdata = 16'(cnt_arr[i]);
                    if (is_cfg) mmio_rdata = 16'(cfg_arr[i]);
                end
            end
        end
    end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed self-checking bench for perf_counter_bank with hand-computed expectations.
module tb_perf_counter_bank;

    localparam int          NUM_CH = 9;
    localparam logic [15:0] BASE   = 16'hFF00;
    localparam logic [15:0] STAT_A = 16'hFF40;
    localparam logic [15:0] CTRL_A = 16'hFF42;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NUM_CH-1:0] event_in = '0;
    logic [15:0]       mmio_addr = '0;
    logic              mmio_read = 1'b0;
    logic              mmio_write = 1'b0;
    logic [15:0]       mmio_wdata = '0;
    logic              mmio_hit;
    logic [15:0]       mmio_rdata;
    logic              overflow_irq;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] rd;
    logic        h;

    perf_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(16), .BASE_ADDR(BASE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .event_in     (event_in),
        .mmio_addr    (mmio_addr),
        .mmio_read    (mmio_read),
        .mmio_write   (mmio_write),
        .mmio_wdata   (mmio_wdata),
        .mmio_hit     (mmio_hit),
        .mmio_rdata   (mmio_rdata),
        .overflow_irq (overflow_irq)
    );

    always #5 clk = ~clk;

    // Combinational read without consuming a clock edge.
    task automatic peek(input logic [15:0] a, output logic [15:0] d, output logic hv);
        mmio_addr = a;
        mmio_read = 1'b1;
        #1;
        d  = mmio_rdata;
        hv = mmio_hit;
        mmio_read = 1'b0;
    endtask

    task automatic mmio_rd(input logic [15:0] a, output logic [15:0] d, output logic hv);
        @(negedge clk);
        peek(a, d, hv);
    endtask

    task automatic mmio_wr(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        mmio_addr  = a;
        mmio_wdata = d;
        mmio_write = 1'b1;
        @(negedge clk);
        mmio_write = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] bad [4];
        bad[0] = BASE + 16'h0044;
        bad[1] = BASE + 16'h0032;
        bad[2] = BASE + 16'h0001;
        bad[3] = 16'hFE00;
        rst_n = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            mmio_rd(BASE + 16'(2 * i), rd, h);
            checks++;
            if (rd !== 16'h0000 || h !== 1'b1) begin
                errors++;
                $display("FAIL reset_cnt%0d: got %h hit %b, want 0000 hit 1", i, rd, h);
            end
            mmio_rd(BASE + 16'h0020 + 16'(2 * i), rd, h);
            checks++;
            if (rd !== 16'h0001 || h !== 1'b1) begin
                errors++;
                $display("FAIL reset_cfg%0d: got %h hit %b, want 0001 hit 1", i, rd, h);
            end
        end
        mmio_rd(STAT_A, rd, h);
        checks++;
        if (rd !== 16'h0000 || h !== 1'b1) begin
            errors++;
            $display("FAIL reset_status: got %h hit %b, want 0000 hit 1", rd, h);
        end
        mmio_rd(CTRL_A, rd, h);
        checks++;
        if (rd !== 16'h0000 || h !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl: got %h hit %b, want 0000 hit 1", rd, h);
        end
        checks++;
        if (overflow_irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq: got %b, want 0", overflow_irq);
        end
        for (int k = 0; k < 4; k++) begin
            mmio_rd(bad[k], rd, h);
            checks++;
            if (rd !== 16'h0000 || h !== 1'b0) begin
                errors++;
                $display("FAIL unmapped_%h: got %h hit %b, want 0000 hit 0", bad[k], rd, h);
            end
        end
        // Write to an unmapped config slot must not disturb channel 0/1 state.
        mmio_wr(BASE + 16'h0032, 16'h00FF);
        mmio_rd(BASE + 16'h0020, rd, h);
        checks++;
        if (rd !== 16'h0001) begin
            errors++;
            $display("FAIL unmapped_write: cfg0 got %h, want 0001", rd);
        end
    endtask

    task automatic test_level_and_run();
        @(negedge clk);
        event_in[0] = 1'b1;
        repeat (5) @(negedge clk);
        event_in[0] = 1'b0;
        peek(BASE, rd, h);
        checks++;
        if (rd !== 16'd5) begin
            errors++;
            $display("FAIL level_count: got %h, want 0005", rd);
        end
        mmio_wr(BASE + 16'h0020, 16'h0023);
        mmio_rd(BASE + 16'h0020, rd, h);
        checks++;
        if (rd !== 16'h0023) begin
            errors++;
            $display("FAIL run_cfg_read: got %h, want 0023", rd);
        end
        @(negedge clk);
        event_in[0] = 1'b1;
        repeat (5) @(negedge clk);
        event_in[0] = 1'b0;
        @(negedge clk);
        event_in[0] = 1'b1;
        repeat (2) @(negedge clk);
        event_in[0] = 1'b0;
        peek(BASE, rd, h);
        checks++;
        if (rd !== 16'd6) begin
            errors++;
            $display("FAIL run_count: got %h, want 0006", rd);
        end
        mmio_wr(BASE + 16'h0026, 16'hFFFF);
        mmio_rd(BASE + 16'h0026, rd, h);
        checks++;
        if (rd !== 16'h00F7) begin
            errors++;
            $display("FAIL cfg_reserved_bits: got %h, want 00F7", rd);
        end
        mmio_wr(BASE + 16'h0026, 16'h0001);
    endtask

    task automatic test_wrap();
        logic [15:0] exp_cnt [3];
        logic [15:0] exp_st [3];
        exp_cnt[0] = 16'hFFFF; exp_cnt[1] = 16'h0000; exp_cnt[2] = 16'h0001;
        exp_st[0]  = 16'h0000; exp_st[1]  = 16'h0002; exp_st[2]  = 16'h0002;
        mmio_wr(BASE + 16'h0002, 16'hFFFE);
        @(negedge clk);
        event_in[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 2) event_in[1] = 1'b0;
            peek(BASE + 16'h0002, rd, h);
            checks++;
            if (rd !== exp_cnt[k]) begin
                errors++;
                $display("FAIL wrap_cnt_step%0d: got %h, want %h", k, rd, exp_cnt[k]);
            end
            peek(STAT_A, rd, h);
            checks++;
            if (rd !== exp_st[k]) begin
                errors++;
                $display("FAIL wrap_status_step%0d: got %h, want %h", k, rd, exp_st[k]);
            end
        end
        checks++;
        if (overflow_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_masked: got %b, want 0", overflow_irq);
        end
        mmio_wr(CTRL_A, 16'h0002);
        #1;
        checks++;
        if (overflow_irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_enabled: got %b, want 1", overflow_irq);
        end
        mmio_wr(STAT_A, 16'h0002);
        peek(STAT_A, rd, h);
        checks++;
        if (rd !== 16'h0000 || overflow_irq !== 1'b0) begin
            errors++;
            $display("FAIL w1c_clear: status %h irq %b, want 0000 irq 0", rd, overflow_irq);
        end
    endtask

    task automatic test_saturate();
        mmio_wr(BASE + 16'h0022, 16'h0005);
        mmio_wr(BASE + 16'h0002, 16'hFFFE);
        @(negedge clk);
        event_in[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 2) event_in[1] = 1'b0;
            peek(BASE + 16'h0002, rd, h);
            checks++;
            if (rd !== 16'hFFFF) begin
                errors++;
                $display("FAIL sat_cnt_step%0d: got %h, want FFFF", k, rd);
            end
        end
        peek(STAT_A, rd, h);
        checks++;
        if (rd !== 16'h0002 || overflow_irq !== 1'b1) begin
            errors++;
            $display("FAIL sat_status: status %h irq %b, want 0002 irq 1", rd, overflow_irq);
        end
        // Overflow and W1C on the same edge: the set must win.
        @(negedge clk);
        event_in[1] = 1'b1;
        mmio_addr   = STAT_A;
        mmio_wdata  = 16'h0002;
        mmio_write  = 1'b1;
        @(negedge clk);
        mmio_write  = 1'b0;
        event_in[1] = 1'b0;
        peek(STAT_A, rd, h);
        checks++;
        if (rd !== 16'h0002) begin
            errors++;
            $display("FAIL set_beats_w1c: got %h, want 0002", rd);
        end
        mmio_wr(STAT_A, 16'h0002);
        mmio_wr(BASE + 16'h0022, 16'h0001);
        peek(STAT_A, rd, h);
        checks++;
        if (rd !== 16'h0000) begin
            errors++;
            $display("FAIL sat_w1c: got %h, want 0000", rd);
        end
    endtask

    task automatic test_freeze();
        mmio_wr(BASE + 16'h0024, 16'h0013);
        mmio_wr(CTRL_A, 16'h0003);
        peek(CTRL_A, rd, h);
        checks++;
        if (rd !== 16'h0003) begin
            errors++;
            $display("FAIL freeze_ctrl: got %h, want 0003", rd);
        end
        @(negedge clk);
        event_in[2] = 1'b1;
        repeat (4) @(negedge clk);
        mmio_wr(CTRL_A, 16'h0002);
        repeat (2) @(negedge clk);
        event_in[2] = 1'b0;
        peek(BASE + 16'h0004, rd, h);
        checks++;
        if (rd !== 16'h0000) begin
            errors++;
            $display("FAIL freeze_run_skip: got %h, want 0000", rd);
        end
        @(negedge clk);
        event_in[2] = 1'b1;
        repeat (2) @(negedge clk);
        event_in[2] = 1'b0;
        peek(BASE + 16'h0004, rd, h);
        checks++;
        if (rd !== 16'h0001) begin
            errors++;
            $display("FAIL unfrozen_run: got %h, want 0001", rd);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        event_in[4] = 1'b1;
        mmio_addr   = BASE + 16'h0008;
        mmio_wdata  = 16'h1234;
        mmio_write  = 1'b1;
        @(negedge clk);
        mmio_write  = 1'b0;
        event_in[4] = 1'b0;
        peek(BASE + 16'h0008, rd, h);
        checks++;
        if (rd !== 16'h1234) begin
            errors++;
            $display("FAIL write_beats_inc: got %h, want 1234", rd);
        end
        @(negedge clk);
        event_in[4] = 1'b1;
        @(negedge clk);
        event_in[4] = 1'b0;
        peek(BASE + 16'h0008, rd, h);
        checks++;
        if (rd !== 16'h1235) begin
            errors++;
            $display("FAIL inc_after_write: got %h, want 1235", rd);
        end
        // Read and write together: rdata shows the pre-write value.
        @(negedge clk);
        mmio_addr  = BASE + 16'h000A;
        mmio_wdata = 16'h0042;
        mmio_read  = 1'b1;
        mmio_write = 1'b1;
        #1;
        rd = mmio_rdata;
        checks++;
        if (rd !== 16'h0000) begin
            errors++;
            $display("FAIL rw_old_value: got %h, want 0000", rd);
        end
        @(negedge clk);
        mmio_write = 1'b0;
        mmio_read  = 1'b0;
        peek(BASE + 16'h000A, rd, h);
        checks++;
        if (rd !== 16'h0042) begin
            errors++;
            $display("FAIL rw_new_value: got %h, want 0042", rd);
        end
    endtask

    task automatic test_clear_all();
        // Counter1 sits at FFFF in wrap mode, so the pre-clear events set status bit1.
        @(negedge clk);
        event_in = '1;
        repeat (2) @(negedge clk);
        mmio_wr(CTRL_A, 16'h0006);
        event_in = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            peek(BASE + 16'(2 * i), rd, h);
            checks++;
            if (rd !== 16'h0000) begin
                errors++;
                $display("FAIL clear_all_cnt%0d: got %h, want 0000", i, rd);
            end
        end
        peek(STAT_A, rd, h);
        checks++;
        if (rd !== 16'h0000 || overflow_irq !== 1'b0) begin
            errors++;
            $display("FAIL clear_all_status: status %h irq %b, want 0000 irq 0", rd, overflow_irq);
        end
        peek(CTRL_A, rd, h);
        checks++;
        if (rd !== 16'h0002) begin
            errors++;
            $display("FAIL clear_all_ctrl: got %h, want 0002", rd);
        end
    endtask

    task automatic test_async_reset();
        mmio_wr(BASE + 16'h0020, 16'h0005);
        @(negedge clk);
        event_in = '1;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        peek(BASE + 16'h0006, rd, h);
        checks++;
        if (rd !== 16'h0000) begin
            errors++;
            $display("FAIL async_rst_cnt3: got %h, want 0000", rd);
        end
        peek(BASE + 16'h0020, rd, h);
        checks++;
        if (rd !== 16'h0001) begin
            errors++;
            $display("FAIL async_rst_cfg0: got %h, want 0001", rd);
        end
        peek(CTRL_A, rd, h);
        checks++;
        if (rd !== 16'h0000 || overflow_irq !== 1'b0) begin
            errors++;
            $display("FAIL async_rst_ctrl: got %h irq %b, want 0000 irq 0", rd, overflow_irq);
        end
        event_in = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        event_in[3] = 1'b1;
        repeat (2) @(negedge clk);
        event_in[3] = 1'b0;
        peek(BASE + 16'h0006, rd, h);
        checks++;
        if (rd !== 16'h0002) begin
            errors++;
            $display("FAIL post_reset_count: got %h, want 0002", rd);
        end
    endtask

    initial begin
        test_reset();
        test_level_and_run();
        test_wrap();
        test_saturate();
        test_freeze();
        test_back_to_back();
        test_clear_all();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/perf_counter_bank.md
Name: perf_counter_bank

Overview:
Parametrised, memory-mapped bank of event counters for the pipelined LC-3b core. It replaces the fixed set of hard-wired cache/branch/stall counters. Each channel has run-time configuration: enable, level or run-threshold mode, and wrap or saturate. The bank adds sticky overflow flags, an optional overflow interrupt, a global freeze and a global clear. It sits beside the MEM stage and answers LDR/STR accesses that fall in its address window.

Parameters:
NUM_CH, 9, number of counter channels (1..16)
CNT_W, 16, counter width in bits (8..16); reads are zero-extended to 16
BASE_ADDR, 16'hFF00, byte address of the window; must be 128-byte aligned

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
event_in  in  NUM_CH  per-channel event level, sampled each rising edge
mmio_addr  in  16  byte address from the MEM stage
mmio_read  in  1  read strobe
mmio_write  in  1  write strobe; full-word writes only
mmio_wdata  in  16  write data
mmio_hit  out  1  address is mapped and a strobe is active (combinational)
mmio_rdata  out  16  read data (combinational); 0 when not hit
overflow_irq  out  1  irq_en AND (status != 0)

Behaviour:
- Address map (offset from BASE_ADDR):
  - 0x00+2i: counter i
  - 0x20+2i: config i
  - 0x40: status
  - 0x42: control
  - All other offsets, and channels >= NUM_CH, are unmapped: hit=0, writes ignored.
- Config format: bit0 enable, bit1 mode (0=level, 1=run), bit2 saturate, bits7:4 thresh. Other bits read 0.
- Status: bit i = sticky overflow flag for channel i. Writing 1 to a bit clears it.
- Control: bit0 freeze, bit1 irq_en, bit2 clear_all. clear_all is write-only, self-clearing and reads 0.
- Reset (async, any time, including mid-operation):
  - Counters 0, status 0, control 0, run trackers 0.
  - Config = 0x0001 (enabled, level mode, wrap, thresh 0).
  - overflow_irq=0. mmio outputs follow the combinational rules.
- Per-channel run tracker run_len (4-bit):
  - Increments while event high, saturating at 15; resets to 0 when event is low.
  - Forced to 0 while the channel is disabled.
  - Keeps tracking while frozen.
- Increment condition, evaluated per edge, only when enable=1 and freeze=0:
  - level mode: event_in[i]=1 (counts cycles).
  - run mode: event_in[i]=1 and run_len==thresh. This counts once per run, on the (thresh+1)-th consecutive high cycle; thresh=0 gives rising-edge counting.
- Overflow, when the counter is all-ones and incrementing:
  - saturate=0: wraps to 0.
  - saturate=1: holds at all-ones.
  - Either way the status bit is set on the same edge.
- Latency: the count is visible to reads on the cycle after the qualifying edge. Reads are combinational and return the pre-edge register value.
- Priority on one edge, highest first:
  1. reset
  2. clear_all (all counters and status to 0; events that cycle are dropped)
  3. MMIO write to counter i (loads mmio_wdata[CNT_W-1:0]; concurrent increment dropped, no overflow set)
  4. increment
- If overflow-set and a W1C status write hit the same bit on the same edge, the set wins.
- Config writes take effect on the next edge. Disabling a channel clears its run tracker on that edge.
- mmio_read and mmio_write asserted together: the write is performed, and rdata shows the old value.

Decomposition:
- Package perf_types:
  - perf_cfg_t packed struct {thresh[3:0], rsvd, sat, mode, en}
  - perf_mode_t enum {PERF_LEVEL, PERF_RUN}
  - Offset constants PERF_CNT_OFS=0x00, PERF_CFG_OFS=0x20, PERF_STAT_OFS=0x40, PERF_CTRL_OFS=0x42
  - Reset config constant PERF_CFG_RST
- Sub-module perf_channel: one counter, run tracker and config register, with write/clear inputs and overflow pulse output. It is instantiated NUM_CH times by generate. The top holds address decode, the status/control registers and the read mux.

Test Plan:
- Reset, then read every mapped address -> counters 0, config 0x0001, status 0, control 0; offset 0x44 and channel 9 config (0x32) -> hit=0, rdata 0.
- Ch0 level mode, event high 5 cycles -> counter0=5; ch0 run mode thresh=2, event high 5 cycles, low 1, high 2 -> counter0 +1 (3rd cycle only), no count for the 2-cycle run.
- Write counter1=0xFFFE, saturate=0, event 3 cycles -> 0xFFFF, then 0x0000, then 0x0001; status bit1=1; with irq_en=1 overflow_irq=1; W1C 0x0002 -> status 0, irq 0.
- Same case with saturate=1 -> counter holds at 0xFFFF, status bit1 set once and stays set.
- Freeze=1 while ch2 run thresh=1 and event high 4 cycles, unfreeze with event still high -> no count, since run_len has already passed thresh.
- Counter write and event on the same edge -> written value, no increment. clear_all with events active -> all counters 0. rst_n pulsed low mid-count, asynchronously between edges -> all registers return to reset values before the next edge.
